// File: rtl/subsys_sequencer.sv
// Power/boot sequencer for up to 16 subsystems: brings them up in ascending index order,
// shuts them down in reverse order, times out stuck handshakes and records the first error.
module subsys_sequencer #(
    parameter int               N_SUB       = 7,
    parameter logic [N_SUB-1:0] DEFER_MASK  = {N_SUB{1'b0}},
    parameter int               TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             defer_go,
    output logic [N_SUB-1:0] init_req,
    input  logic [N_SUB-1:0] init_ack,
    output logic [N_SUB-1:0] shut_req,
    input  logic [N_SUB-1:0] shut_ack,
    output logic [N_SUB-1:0] alive,
    output logic             healthy,
    output logic             busy,
    output logic [2:0]       state,
    output logic             err,
    output logic [3:0]       err_idx,
    output logic [1:0]       err_code
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_RUN   = 3'd2,
        ST_SHUT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int             TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TLAST = TW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    function automatic logic [N_SUB-1:0] low_onehot(input logic [N_SUB-1:0] v);
        logic [N_SUB-1:0] r;
        logic             found;
        r     = {N_SUB{1'b0}};
        found = 1'b0;
        for (int i = 0; i < N_SUB; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [N_SUB-1:0] high_onehot(input logic [N_SUB-1:0] v);
        logic [N_SUB-1:0] r;
        logic             found;
        r     = {N_SUB{1'b0}};
        found = 1'b0;
        for (int i = N_SUB - 1; i >= 0; i--) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot_idx(input logic [N_SUB-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < N_SUB; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [N_SUB-1:0] target_r, target_nxt_s;
    logic [N_SUB-1:0] alive_r, alive_nxt_s;
    logic [N_SUB-1:0] init_req_r, init_req_nxt_s;
    logic [N_SUB-1:0] shut_req_r, shut_req_nxt_s;
    logic [TW-1:0]    timer_r, timer_nxt_s;
    logic             healthy_r, healthy_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             err_r, err_nxt_s;
    logic [3:0]       err_idx_r, err_idx_nxt_s;
    logic [1:0]       err_code_r, err_code_nxt_s;
    logic             timeout_s;
    logic [N_SUB-1:0] init_hit_s, shut_hit_s, stray_s;

    // Next-state, bookkeeping and next-cycle output values
    always_comb begin
        state_nxt_s    = state_r;
        target_nxt_s   = target_r;
        alive_nxt_s    = alive_r;
        err_nxt_s      = err_r;
        err_idx_nxt_s  = err_idx_r;
        err_code_nxt_s = err_code_r;
        timeout_s      = (TIMEOUT_CYC != 0) && (timer_r == TLAST);
        init_hit_s     = init_ack & init_req_r;
        shut_hit_s     = shut_ack & shut_req_r;
        stray_s        = (init_ack & ~init_req_r) | (shut_ack & ~shut_req_r);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    target_nxt_s   = ~DEFER_MASK;
                    err_nxt_s      = 1'b0;
                    err_idx_nxt_s  = 4'd0;
                    err_code_nxt_s = 2'b00;
                    if ((~DEFER_MASK & ~alive_r) != {N_SUB{1'b0}}) state_nxt_s = ST_INIT;
                    else                                            state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                // An ack coinciding with stop still marks the subsystem as up
                alive_nxt_s = alive_r | init_hit_s;
                if (stop) begin
                    state_nxt_s = ST_SHUT;
                end else if ((init_req_r != {N_SUB{1'b0}}) && (init_hit_s == {N_SUB{1'b0}}) && timeout_s) begin
                    state_nxt_s = ST_FAULT;
                    if (!err_r) begin
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = 2'b01;
                        err_idx_nxt_s  = onehot_idx(init_req_r);
                    end else begin
                        err_nxt_s = err_r;
                    end
                end else if ((target_r & ~alive_nxt_s) == {N_SUB{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_SHUT;
                end else if (defer_go) begin
                    target_nxt_s = {N_SUB{1'b1}};
                    if (~alive_r != {N_SUB{1'b0}}) state_nxt_s = ST_INIT;
                    else                           state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SHUT: begin
                // A timed-out subsystem is treated as down so shutdown always completes
                if ((shut_req_r != {N_SUB{1'b0}}) && ((shut_hit_s != {N_SUB{1'b0}}) || timeout_s)) begin
                    alive_nxt_s = alive_r & ~shut_req_r;
                    if ((shut_hit_s == {N_SUB{1'b0}}) && !err_r) begin
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = 2'b10;
                        err_idx_nxt_s  = onehot_idx(shut_req_r);
                    end else begin
                        err_nxt_s = err_r;
                    end
                end else begin
                    alive_nxt_s = alive_r;
                end
                if (alive_nxt_s == {N_SUB{1'b0}}) state_nxt_s = ST_IDLE;
                else                              state_nxt_s = ST_SHUT;
            end
            ST_FAULT: begin
                if (stop) state_nxt_s = ST_SHUT;
                else      state_nxt_s = ST_FAULT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if ((stray_s != {N_SUB{1'b0}}) && !err_nxt_s) begin
            err_nxt_s      = 1'b1;
            err_code_nxt_s = 2'b11;
            err_idx_nxt_s  = onehot_idx(low_onehot(stray_s));
        end else begin
            err_nxt_s = err_nxt_s;
        end

        init_req_nxt_s = (state_nxt_s == ST_INIT) ? low_onehot(target_nxt_s & ~alive_nxt_s) : {N_SUB{1'b0}};
        shut_req_nxt_s = (state_nxt_s == ST_SHUT) ? high_onehot(alive_nxt_s) : {N_SUB{1'b0}};
        healthy_nxt_s  = (state_nxt_s == ST_RUN) && ((alive_nxt_s & ~DEFER_MASK) == ~DEFER_MASK);
        busy_nxt_s     = (state_nxt_s == ST_INIT) || (state_nxt_s == ST_SHUT);

        // Timer restarts whenever the active request changes
        if (((init_req_nxt_s | shut_req_nxt_s) != {N_SUB{1'b0}}) &&
            (init_req_nxt_s == init_req_r) && (shut_req_nxt_s == shut_req_r)) begin
            timer_nxt_s = timer_r + TW'(1);
        end else begin
            timer_nxt_s = {TW{1'b0}};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            target_r   <= {N_SUB{1'b0}};
            alive_r    <= {N_SUB{1'b0}};
            init_req_r <= {N_SUB{1'b0}};
            shut_req_r <= {N_SUB{1'b0}};
            timer_r    <= {TW{1'b0}};
            healthy_r  <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            err_idx_r  <= 4'd0;
            err_code_r <= 2'b00;
        end else begin
            state_r    <= state_nxt_s;
            target_r   <= target_nxt_s;
            alive_r    <= alive_nxt_s;
            init_req_r <= init_req_nxt_s;
            shut_req_r <= shut_req_nxt_s;
            timer_r    <= timer_nxt_s;
            healthy_r  <= healthy_nxt_s;
            busy_r     <= busy_nxt_s;
            err_r      <= err_nxt_s;
            err_idx_r  <= err_idx_nxt_s;
            err_code_r <= err_code_nxt_s;
        end
    end

    assign init_req = init_req_r;
    assign shut_req = shut_req_r;
    assign alive    = alive_r;
    assign healthy  = healthy_r;
    assign busy     = busy_r;
    assign state    = state_r;
    assign err      = err_r;
    assign err_idx  = err_idx_r;
    assign err_code = err_code_r;

endmodule

// File: tb/tb_subsys_sequencer.sv
// Directed self-checking bench for subsys_sequencer with 4 subsystems, index 2 deferred, 8-cycle timeout.
module tb_subsys_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, defer_go = 1'b0;
    logic [3:0] init_req, init_ack = 4'b0000, shut_req, shut_ack = 4'b0000, alive;
    logic       healthy, busy, err;
    logic [2:0] state;
    logic [3:0] err_idx;
    logic [1:0] err_code;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    subsys_sequencer #(.N_SUB(4), .DEFER_MASK(4'b0100), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .defer_go(defer_go),
        .init_req(init_req), .init_ack(init_ack), .shut_req(shut_req), .shut_ack(shut_ack),
        .alive(alive), .healthy(healthy), .busy(busy), .state(state),
        .err(err), .err_idx(err_idx), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request observed now; ack sampled two edges after the request rose
    task automatic init_step(input logic [3:0] exp, input string tag);
        check(tag, init_req, exp);
        tick();
        init_ack = exp;
        tick();
        init_ack = 4'b0000;
    endtask

    task automatic shut_step(input logic [3:0] exp, input string tag);
        check(tag, shut_req, exp);
        shut_ack = exp;
        tick();
        shut_ack = 4'b0000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_state", state, 3'd0);
        check("rst_outs", {init_req, shut_req, alive, healthy, busy, err, err_idx, err_code}, 23'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_in_idle", state, 3'd0);

        // Boot with index 2 deferred
        pulse_start();
        check("boot_state", state, 3'd1);
        check("boot_busy", busy, 1'b1);
        init_step(4'b0001, "boot_req0");
        init_step(4'b0010, "boot_req1");
        check("boot_alive_mid", alive, 4'b0011);
        init_step(4'b1000, "boot_req3");
        check("boot_alive", alive, 4'b1011);
        check("boot_run", state, 3'd2);
        check("boot_healthy", healthy, 1'b1);
        check("boot_idle_req", {init_req, busy}, 5'd0);
        pulse_start();
        check("start_ignored_run", state, 3'd2);

        // Deferred subsystem
        defer_go = 1'b1; tick(); defer_go = 1'b0;
        check("defer_state", state, 3'd1);
        init_step(4'b0100, "defer_req");
        check("defer_alive", alive, 4'b1111);
        check("defer_run", state, 3'd2);

        // Orderly shutdown
        pulse_stop();
        check("shut_state", state, 3'd3);
        shut_step(4'b1000, "shut_req3");
        shut_step(4'b0100, "shut_req2");
        shut_step(4'b0010, "shut_req1");
        shut_step(4'b0001, "shut_req0");
        check("shut_idle", state, 3'd0);
        check("shut_alive", alive, 4'b0000);
        check("shut_noerr", err, 1'b0);

        // Init timeout on index 1
        pulse_start();
        init_step(4'b0001, "to_req0");
        cnt = 0;
        while (init_req[1] && cnt < 20) begin
            cnt++;
            tick();
        end
        check("to_req_len", cnt, 8);
        check("to_fault", state, 3'd4);
        check("to_err", {err, err_code, err_idx}, {1'b1, 2'b01, 4'd1});
        check("to_alive", alive, 4'b0001);
        tick(); tick();
        check("fault_hold", {state, init_req, shut_req, alive}, {3'd4, 4'b0000, 4'b0000, 4'b0001});
        pulse_stop();
        check("fault_stop", state, 3'd3);
        shut_step(4'b0001, "fault_shut0");
        check("fault_idle", {state, alive}, {3'd0, 4'b0000});
        check("err_sticky", {err, err_code}, {1'b1, 2'b01});

        // Shutdown timeout with a stray ack
        pulse_start();
        check("start_clr_err", {err, err_code}, 3'd0);
        init_step(4'b0001, "b2_req0");
        init_step(4'b0010, "b2_req1");
        init_step(4'b1000, "b2_req3");
        defer_go = 1'b1; tick(); defer_go = 1'b0;
        init_step(4'b0100, "b2_req2");
        check("b2_alive", alive, 4'b1111);
        pulse_stop();
        check("st_req3", shut_req, 4'b1000);
        init_ack = 4'b0001; tick(); init_ack = 4'b0000;
        check("stray_err", {err, err_code, err_idx, state}, {1'b1, 2'b11, 4'd0, 3'd3});
        cnt = 0;
        while (shut_req[3] && cnt < 20) begin
            cnt++;
            tick();
        end
        check("st_len", cnt, 7);
        check("st_alive", alive, 4'b0111);
        check("st_code_kept", err_code, 2'b11);
        shut_step(4'b0100, "st_req2");
        shut_step(4'b0010, "st_req1");
        shut_step(4'b0001, "st_req0");
        check("st_idle", state, 3'd0);

        // Asynchronous reset mid-INIT, then reboot
        pulse_start();
        init_step(4'b0001, "r_req0");
        check("r_req1", init_req, 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("arst_outs", {state, init_req, shut_req, alive, healthy, busy, err, err_idx, err_code}, 26'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_start();
        check("reboot", {state, init_req}, {3'd1, 4'b0001});

        // Ack in the same cycle as stop counts as alive
        init_ack = 4'b0001; stop = 1'b1;
        tick();
        init_ack = 4'b0000; stop = 1'b0;
        check("ack_stop", {state, shut_req, init_req, alive}, {3'd3, 4'b0001, 4'b0000, 4'b0001});
        shut_step(4'b0001, "ack_stop_shut");
        check("ack_stop_idle", state, 3'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/subsys_sequencer.md
SUBSYS_SEQUENCER -- requirements
Module: subsys_sequencer

Interface
REQ-001 SHALL have parameter N_SUB, default 7, meaning number of managed subsystems (1..16); index 0 is brought up first.
REQ-002 SHALL have parameter DEFER_MASK, default 0, meaning an N_SUB-bit mask of subsystems skipped during boot and brought up only on defer_go.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum number of cycles a request may stay high without ack; 0 disables the timeout.
REQ-004 SHALL have ports clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports start  in  1  begin boot (pulse); stop  in  1  begin shutdown (pulse); defer_go  in  1  bring up deferred subsystems (pulse).
REQ-006 SHALL have ports init_req  out  N_SUB  per-subsystem init request; init_ack  in  N_SUB  init done.
REQ-007 SHALL have ports shut_req  out  N_SUB  per-subsystem shutdown request; shut_ack  in  N_SUB  shutdown done.
REQ-008 SHALL have ports alive  out  N_SUB  subsystem up; healthy  out  1  state RUN and every non-deferred bit of alive set; busy  out  1  state INIT or SHUT.
REQ-009 SHALL have ports state  out  3  IDLE=0, INIT=1, RUN=2, SHUT=3, FAULT=4; err  out  1  sticky error; err_idx  out  4  subsystem index of first error; err_code  out  2  01 init timeout, 10 shutdown timeout, 11 stray ack.

Function
REQ-010 SHALL keep init_req and shut_req each at most one-hot, and never both nonzero in the same cycle.
REQ-011 SHALL hold an internal target mask; start loads ~DEFER_MASK, and defer_go accepted in RUN sets it to all ones.
REQ-012 In INIT, SHALL request the lowest index i with target[i]=1 and alive[i]=0; when none remains, state SHALL become RUN the next cycle.
REQ-013 IDLE + start: next cycle state=INIT, err cleared, and init_req of the first target index high; if the target is empty, go straight to RUN.
REQ-014 init_ack[i] sampled high while init_req[i] is high: next cycle alive[i]=1 and init_req moves to the next index or clears; no idle cycle between requests.
REQ-015 Timeout: a per-request timer starts at 0 on the first request cycle; ack absent at timer=TIMEOUT_CYC-1 -> next cycle state=FAULT, init_req=0, err=1, err_code=01, err_idx=i.
REQ-016 RUN + defer_go with any target bit not alive: next cycle state=INIT; defer_go in any other state SHALL be ignored.
REQ-017 stop in INIT, RUN or FAULT: next cycle state=SHUT and any pending init_req dropped; a subsystem that acks in the same cycle as stop SHALL count as alive.
REQ-018 In SHUT, SHALL request the highest index with alive=1 (reverse boot order); shut_ack -> next cycle alive bit cleared and request moves on; when alive=0, state SHALL become IDLE.
REQ-019 Shutdown timeout (same timer rule as REQ-015): SHALL clear the alive bit anyway, continue shutdown, and record err_code=10 only if err was 0.
REQ-020 An ack bit high on an index not currently requested SHALL set err, err_code=11, err_idx only if err was 0; no state change.
REQ-021 Only the first error SHALL be recorded; err, err_idx and err_code SHALL hold until the next accepted start or reset.
REQ-022 start in any state other than IDLE SHALL be ignored; stop in IDLE or SHUT SHALL be ignored; start and stop together in IDLE -> start wins.
REQ-023 FAULT SHALL keep alive unchanged and hold all requests low until stop.
REQ-024 When TIMEOUT_CYC=0, the timer SHALL never fire.

Reset
REQ-025 rst high SHALL immediately force state=IDLE, every output 0, and the target mask and timer to 0.
REQ-026 Reset mid-operation SHALL drop requests asynchronously; no shutdown sequence is run.
REQ-027 The first rising clk edge after rst deasserts SHALL act on inputs normally.

Verification (N_SUB=4, DEFER_MASK=4'b0100, TIMEOUT_CYC=8)
REQ-028 Boot: start; ack each request 2 cycles after it rises -> init_req sequence 0001,0010,1000; alive=1011; RUN; healthy=1.
REQ-029 Deferred boot: from REQ-028, pulse defer_go -> INIT, init_req=0100; after ack, alive=1111 and state RUN.
REQ-030 Init timeout: start; never ack index 1 -> init_req[1] high exactly 8 cycles; then FAULT, err_code=01, err_idx=1, alive=0001; stop -> shut_req=0001 -> IDLE.
REQ-031 Shutdown: alive=1111, stop; ack each request -> shut_req order 1000,0100,0010,0001; then IDLE with alive=0.
REQ-032 Shutdown timeout plus stray ack: during SHUT, withhold shut_ack[3] and pulse init_ack[0] -> err_code=11, err_idx=0; timeout still clears alive[3]; err_code stays 11.
REQ-033 Reset mid-INIT: assert rst while init_req=0010 -> outputs 0 with no clock edge; after release, start reboots from index 0.
